serial_rx: RTL and testbench
============================

SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port nRst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port rx  input  1  serial data line; idle high; bits LSB first, one bit per clk.
REQ-004 SHALL have port start  input  1  frame-start strobe, asserted in the same cycle the far-end transmitter is told to send.
REQ-005 SHALL have port len  input  3  frame length in bytes; 1..6 valid.
REQ-006 SHALL have port rd  input  1  pop strobe for the presented byte.
REQ-007 SHALL have port data  output  8  byte currently presented; 0 when not valid.
REQ-008 SHALL have port valid  output  1  high while a received byte is presented on data.
REQ-009 SHALL have port busy  output  1  high in ALIGN and RECV.
REQ-010 SHALL have port done  output  1  one-cycle pulse on the cycle after the last bit is sampled.

Function
REQ-011 SHALL implement four states: IDLE, ALIGN, RECV, HOLD.
REQ-012 In IDLE, start=1 with len in 1..6 SHALL latch nbits=8*len, clear bit index and the 48-bit buffer, and move to ALIGN.
REQ-013 len=7 SHALL be clamped to 6 bytes (48 bits).
REQ-014 len=0 with start=1 SHALL be ignored; state remains IDLE.
REQ-015 ALIGN SHALL last exactly one cycle, then move to RECV with no rx sample.
REQ-016 Latency: with start sampled at edge E0, the first rx sample SHALL occur at edge E2 and the last at edge E(1+nbits).
REQ-017 In RECV, each edge SHALL write rx into buffer[bitidx] and increment bitidx (6-bit).
REQ-018 On the edge that samples bit nbits-1, state SHALL move to HOLD, and done SHALL be high for the following cycle only.
REQ-019 Byte i SHALL equal buffer[8i+7:8i]; byte 0 is the first byte on the line.
REQ-020 In HOLD, valid SHALL be 1, and data SHALL equal byte rdptr, with rdptr reset to 0 on entry.
REQ-021 rd=1 in HOLD SHALL increment rdptr on that edge; if rdptr was len-1, state SHALL return to IDLE and valid SHALL fall on the next cycle.
REQ-022 rd outside HOLD SHALL be ignored.
REQ-023 start outside IDLE (ALIGN, RECV, HOLD) SHALL be ignored; no restart and no change to the latched len.
REQ-024 In IDLE, busy=0, valid=0 and data=0; rx SHALL be ignored.
REQ-025 The block SHALL NOT check rx framing; rx is sampled blindly during the RECV window.

Reset
REQ-026 nRst low SHALL immediately force state=IDLE, buffer=0, bitidx=0, rdptr=0, nbits=0, data=0, valid=0, busy=0, done=0.
REQ-027 Reset asserted mid-RECV or mid-HOLD SHALL discard all partial data; after release, the block SHALL accept a new start normally.
REQ-028 After deassertion, the first start SHALL be honoured on the first rising edge where nRst is high.

Verification
REQ-029 start, len=1; rx carries 0xA5 LSB first on edges E2..E9 -> done pulses after E9; valid=1, data=0xA5; one rd -> valid=0 and state returns to IDLE.
REQ-030 start, len=6; rx carries bytes 0x01,0x23,0x45,0x67,0x89,0xAB -> six rd pops present them in that order; after the sixth pop, valid=0.
REQ-031 start with len=0 -> busy stays 0 and no done; start with len=7 -> 48 bits are captured and six bytes are presented.
REQ-032 Second start pulsed during RECV of a len=2 frame of 0x3C,0xC3 -> frame unaffected; data=0x3C then 0xC3; no extra frame follows.
REQ-033 nRst pulsed low at bit 12 of a len=2 frame -> all outputs 0 immediately; a new len=1 frame of 0x5A then receives 0x5A correctly.
REQ-034 Back-to-back operation with a serial transmitter sending 3 bytes 0xDE,0xAD,0xBE, with send and start strobed in the same cycle -> bytes are received bit-exact and in order.

Source files
------------

// File: rtl/serial_rx_if.sv
// serial_rx_if -- bundles the serial line, frame control and byte read-out
// signals of serial_rx.
//   rx    : serial data line (idle high, LSB first, one bit per clk)
//   start : frame-start strobe
//   len   : frame length in bytes (1..6, 7 is clamped to 6, 0 ignored)
//   rd    : pop strobe for the presented byte
//   data  : byte currently presented (0 when valid is low)
//   valid : a received byte is presented on data
//   busy  : receiver is aligning or receiving
//   done  : one-cycle pulse after the last bit of a frame is sampled
// The master modport drives the line and control; the slave modport is the
// receiver.
interface serial_rx_if;
  logic       rx;
  logic       start;
  logic [2:0] len;
  logic       rd;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       done;

  modport master (
    output rx, start, len, rd,
    input  data, valid, busy, done
  );

  modport slave (
    input  rx, start, len, rd,
    output data, valid, busy, done
  );
endinterface

// File: rtl/serial_rx.sv
// serial_rx -- fixed-latency serial frame receiver.
// A start strobe in IDLE latches the frame length, spends one ALIGN cycle,
// then samples rx blindly for 8*len cycles into a 48-bit buffer (bit i of
// the frame lands in buffer[i]). The frame is then held and presented one
// byte at a time; each rd pops the current byte, and popping the last byte
// returns to IDLE.
// Ports:
//   clk  : clock, rising edge
//   nRst : asynchronous active-low reset
//   bus  : serial_rx_if.slave (rx, start, len, rd in; data, valid, busy, done out)
module serial_rx (
  input  logic        clk,
  input  logic        nRst,
  serial_rx_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ALIGN, RECV, HOLD} state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [47:0] r_buf;
  logic [5:0]  r_bitidx;
  logic [5:0]  r_nbits;
  logic [2:0]  r_len;
  logic [2:0]  r_rdptr;
  logic        r_done;

  logic [2:0]  w_len_eff;
  logic        w_accept;
  logic        w_last_bit;
  logic        w_pop_last;
  logic [47:0] w_bit_we;
  logic [7:0]  w_bytes [6];
  logic [7:0]  w_data;

  // len=7 is treated as the maximum frame of 6 bytes
  assign w_len_eff  = (bus.len == 3'd7) ? 3'd6 : bus.len;
  assign w_accept   = (r_state == IDLE) && bus.start && (bus.len != 3'd0);
  assign w_last_bit = (r_state == RECV) && (r_bitidx == (r_nbits - 6'd1));
  assign w_pop_last = (r_state == HOLD) && bus.rd && (r_rdptr == (r_len - 3'd1));

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)   w_state_next = ALIGN;
      ALIGN:                   w_state_next = RECV;
      RECV:    if (w_last_bit) w_state_next = HOLD;
      HOLD:    if (w_pop_last) w_state_next = IDLE;
      default:                 w_state_next = IDLE;
    endcase
  end

  // ---------------- counters and done pulse ----------------
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_bitidx <= 6'd0;
      r_nbits  <= 6'd0;
      r_len    <= 3'd0;
      r_rdptr  <= 3'd0;
      r_done   <= 1'b0;
    end else begin
      // done is high exactly in the cycle after the last bit is sampled
      r_done <= w_last_bit;
      if (w_accept) begin
        r_len    <= w_len_eff;
        r_nbits  <= {w_len_eff, 3'b000};
        r_bitidx <= 6'd0;
      end else if (r_state == RECV) begin
        r_bitidx <= r_bitidx + 6'd1;
      end
      if (w_last_bit) begin
        r_rdptr <= 3'd0;
      end else if ((r_state == HOLD) && bus.rd) begin
        r_rdptr <= r_rdptr + 3'd1;
      end
    end
  end

  // ---------------- bit capture ----------------
  // One write-enable per buffer bit, decoded from the bit index.
  genvar gi;
  generate
    for (gi = 0; gi < 48; gi++) begin : g_bit_we
      assign w_bit_we[gi] = (r_state == RECV) && (r_bitidx == 6'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_buf <= 48'd0;
    end else if (w_accept) begin
      r_buf <= 48'd0;
    end else begin
      r_buf <= (r_buf & ~w_bit_we) | (w_bit_we & {48{bus.rx}});
    end
  end

  // ---------------- byte presentation ----------------
  generate
    for (gi = 0; gi < 6; gi++) begin : g_bytes
      assign w_bytes[gi] = r_buf[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    w_data = 8'd0;
    if (r_state == HOLD) begin
      case (r_rdptr)
        3'd0:    w_data = w_bytes[0];
        3'd1:    w_data = w_bytes[1];
        3'd2:    w_data = w_bytes[2];
        3'd3:    w_data = w_bytes[3];
        3'd4:    w_data = w_bytes[4];
        3'd5:    w_data = w_bytes[5];
        default: w_data = 8'd0;
      endcase
    end
  end

  assign bus.data  = w_data;
  assign bus.valid = (r_state == HOLD);
  assign bus.busy  = (r_state == ALIGN) || (r_state == RECV);
  assign bus.done  = r_done;

endmodule

// File: tb/tb_serial_rx.sv
module tb_serial_rx;

  logic clk = 1'b0;
  logic nRst;
  always #5 clk = ~clk;

  serial_rx_if bus_if ();

  serial_rx dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus_if)
  );

  // rx source: direct bench drive or the small serial transmitter model
  logic        rx_direct = 1'b1;
  logic        tx_sel    = 1'b0;
  logic        tx_line   = 1'b1;
  logic        send      = 1'b0;
  logic [47:0] tx_data   = 48'd0;
  int          tx_nbits  = 0;
  logic [47:0] tx_sr     = 48'd0;
  int          tx_cnt    = 0;

  assign bus_if.rx = tx_sel ? tx_line : rx_direct;

  // Transmitter: loads on send, drives bit 0 after the next edge, then one
  // bit per clock, idle high afterwards.
  always @(posedge clk) begin
    if (send) begin
      tx_sr  <= tx_data;
      tx_cnt <= tx_nbits;
    end else if (tx_cnt > 0) begin
      tx_line <= tx_sr[0];
      tx_sr   <= tx_sr >> 1;
      tx_cnt  <= tx_cnt - 1;
    end else begin
      tx_line <= 1'b1;
    end
  end

  int         errors   = 0;
  int         checks   = 0;
  int         done_cnt = 0;
  int         exp_done = 0;
  logic [7:0] exp_q [$];

  function automatic void check(string name, logic [47:0] act, logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard whenever a byte is consumed.
  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (nRst === 1'b1) begin
      if (bus_if.done === 1'b1) done_cnt++;
      if (bus_if.valid === 1'b1 && bus_if.rd === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 48'(bus_if.data), 48'h1_0000);
        end else begin
          e = exp_q.pop_front();
          $display("pop: data=%02h expected=%02h", bus_if.data, e);
          check("pop_data", 48'(bus_if.data), 48'(e));
        end
      end
      if (bus_if.valid !== 1'b1) check("data_zero_when_invalid", 48'(bus_if.data), 48'd0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_data"},  48'(bus_if.data),  48'd0);
    check({tag, "_valid"}, 48'(bus_if.valid), 48'd0);
    check({tag, "_busy"},  48'(bus_if.busy),  48'd0);
    check({tag, "_done"},  48'(bus_if.done),  48'd0);
  endtask

  // Drive one frame directly on rx. restart_at/abort_at select the bit index
  // at which a spurious start or a reset is injected (-1 = none).
  task automatic send_frame(input logic [2:0] l, input logic [47:0] payload,
                            input int nbytes, input int restart_at, input int abort_at);
    int nbits;
    nbits = nbytes * 8;
    for (int b = 0; b < nbytes; b++) exp_q.push_back(payload[8*b +: 8]);
    $display("frame: len=%0d payload=%012h", l, payload);
    bus_if.len   = l;
    bus_if.start = 1'b1;
    tick;                                   // E0
    bus_if.start = 1'b0;
    check("busy_align", 48'(bus_if.busy), 48'd1);
    tick;                                   // E1, no sample
    for (int i = 0; i < nbits; i++) begin
      rx_direct = payload[i];
      if (i == restart_at) begin
        bus_if.start = 1'b1;
        bus_if.len   = 3'd5;
      end else begin
        bus_if.start = 1'b0;
      end
      if (i == abort_at) begin
        #2 nRst = 1'b0;
        #1;
        check_all_zero("reset_mid_frame");
        exp_q.delete();
        rx_direct    = 1'b1;
        bus_if.start = 1'b0;
        return;
      end
      tick;                                 // samples bit i at E(2+i)
    end
    rx_direct    = 1'b1;
    bus_if.start = 1'b0;
    exp_done++;
    check("done_pulse",  48'(bus_if.done),  48'd1);
    check("valid_hold",  48'(bus_if.valid), 48'd1);
    check("busy_hold",   48'(bus_if.busy),  48'd0);
    check("first_byte",  48'(bus_if.data),  48'(payload[7:0]));
    tick;
    check("done_one_cycle", 48'(bus_if.done), 48'd0);
  endtask

  task automatic pop_all(input int n);
    int budget;
    budget = 0;
    while (bus_if.valid !== 1'b1 && budget < 100) begin
      tick;
      budget++;
    end
    if (bus_if.valid !== 1'b1) begin
      check("wait_valid_timeout", 48'(bus_if.valid), 48'd1);
      return;
    end
    for (int k = 0; k < n; k++) begin
      bus_if.rd = 1'b1;
      tick;
      bus_if.rd = 1'b0;
    end
    check("valid_after_last_pop", 48'(bus_if.valid), 48'd0);
    check("busy_after_last_pop",  48'(bus_if.busy),  48'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    int budget;
    nRst         = 1'b0;
    bus_if.start = 1'b0;
    bus_if.len   = 3'd0;
    bus_if.rd    = 1'b0;
    #2;
    check_all_zero("reset_state");
    tick;
    tick;
    nRst = 1'b1;
    tick;

    // len=1, 0xA5
    send_frame(3'd1, 48'hA5, 1, -1, -1);
    pop_all(1);

    // len=6, 01 23 45 67 89 AB
    send_frame(3'd6, 48'hAB8967452301, 6, -1, -1);
    pop_all(6);

    // len=0 is ignored
    $display("frame: len=0 (ignored)");
    bus_if.len   = 3'd0;
    bus_if.start = 1'b1;
    tick;
    bus_if.start = 1'b0;
    check("len0_busy", 48'(bus_if.busy), 48'd0);
    tick;
    tick;
    check("len0_busy_later", 48'(bus_if.busy),  48'd0);
    check("len0_valid",      48'(bus_if.valid), 48'd0);

    // len=7 clamps to 6 bytes
    send_frame(3'd7, 48'h112233445566, 6, -1, -1);
    pop_all(6);

    // spurious start during RECV of a len=2 frame
    send_frame(3'd2, 48'hC33C, 2, 5, -1);
    pop_all(2);
    repeat (20) tick;
    check("no_extra_frame_busy",  48'(bus_if.busy),  48'd0);
    check("no_extra_frame_valid", 48'(bus_if.valid), 48'd0);

    // reset at bit 12 of a len=2 frame, then a clean len=1 frame
    send_frame(3'd2, 48'h1234, 2, -1, 12);
    tick;
    nRst = 1'b1;
    send_frame(3'd1, 48'h5A, 1, -1, -1);
    pop_all(1);

    // transmitter model, 3 bytes DE AD BE, send and start together
    $display("frame: transmitter len=3 bytes DE AD BE");
    tx_data  = 48'hBEADDE;
    tx_nbits = 24;
    tx_sel   = 1'b1;
    exp_q.push_back(8'hDE);
    exp_q.push_back(8'hAD);
    exp_q.push_back(8'hBE);
    bus_if.len   = 3'd3;
    bus_if.start = 1'b1;
    send         = 1'b1;
    tick;
    bus_if.start = 1'b0;
    send         = 1'b0;
    exp_done++;
    budget = 0;
    while (bus_if.done !== 1'b1 && budget < 60) begin
      tick;
      budget++;
    end
    check("tx_done_seen", 48'(bus_if.done), 48'd1);
    check("tx_done_latency", 48'(budget), 48'd25);
    pop_all(3);
    tx_sel = 1'b0;

    repeat (3) tick;
    check("done_count",  48'(done_cnt),     48'(exp_done));
    check("queue_empty", 48'(exp_q.size()), 48'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
